// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the frequency meter.
package freq_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    // Defaults: a 1 s gate at 100 MHz gives the result directly in Hz
    localparam int DEF_GATE_CYCLES = 100_000_000;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_GATE_W      = 27;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus one delay flop and a rising-edge detector.
// Safe to reuse for any input that is asynchronous to clk.
module sync_edge_det
    import freq_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronize the async input and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of sig_in over a gate of GATE_CYCLES
// clk cycles and latches the count. Optional period measurement between
// consecutive rising edges is compiled in when PERIOD_MEAS_EN is defined.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_W      = DEF_GATE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             ovf,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_int;
    logic              rise;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sig_in),
        .rise     (rise)
    );

    assign busy = (state != IDLE);

    // Gate FSM, saturating edge counter and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_int    <= 1'b0;
            freq_out   <= '0;
            ovf        <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= GATE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_int  <= 1'b0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt + GATE_W'(1);
                    if (rise) begin
                        if (edge_cnt == CNT_MAX) begin
                            ovf_int <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + CNT_W'(1);
                        end
                    end
                    if (gate_cnt == GATE_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    freq_out   <= edge_cnt;
                    ovf        <= ovf_int;
                    freq_valid <= 1'b1;
                    if (cont) begin
                        state    <= GATE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_int  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERIOD_MEAS_EN
    logic [CNT_W-1:0] per_cnt;
    logic             seen_rise;

    // Free-running period counter; the first rise after reset only arms it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt      <= '0;
            seen_rise    <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (rise) begin
                per_cnt   <= '0;
                seen_rise <= 1'b1;
                if (seen_rise) begin
                    period_valid <= 1'b1;
                    period_out   <= (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CNT_W'(1);
                end
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign period_out   = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter with a shortened gate of 1000 cycles.
module tb_freq_meter;

    localparam int GC   = 1000;
    localparam int MAXC = 40000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sig_in = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        start4 = 1'b0;

    logic        busy;
    logic [31:0] freq_out;
    logic        freq_valid;
    logic        ovf;
    logic [31:0] period_out;
    logic        period_valid;

    logic        busy4;
    logic [3:0]  freq_out4;
    logic        freq_valid4;
    logic        ovf4;
    logic [3:0]  period_out4;
    logic        period_valid4;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(32), .GATE_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .start        (start),
        .cont         (cont),
        .busy         (busy),
        .freq_out     (freq_out),
        .freq_valid   (freq_valid),
        .ovf          (ovf),
        .period_out   (period_out),
        .period_valid (period_valid)
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(4), .GATE_W(10)) dut_narrow (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .start        (start4),
        .cont         (1'b0),
        .busy         (busy4),
        .freq_out     (freq_out4),
        .freq_valid   (freq_valid4),
        .ovf          (ovf4),
        .period_out   (period_out4),
        .period_valid (period_valid4)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit hist [0:MAXC-1];

    int gen_period = 0;
    int gen_high = 0;
    int gen_phase = 0;

    bit          m_active = 1'b0;
    int          m_s = 0;
    logic [63:0] m_freq = '0;
    logic        m_ovf = 1'b0;
    int          valid_cnt = 0;

    typedef struct {
        int t;
        int v;
    } pev_t;
    pev_t pq[$];
    int   prev_rise = -1;
    int   pulse_cnt = 0;

    typedef struct {
        int period;
        int high;
        int lo;
        int hi;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Number of sig_in rising edges driven in cycles lo..hi
    function automatic int count_rises(input int lo, input int hi);
        int n;
        n = 0;
        for (int c = lo; c <= hi; c++) begin
            if (c > 0 && c < MAXC && hist[c] && !hist[c-1]) n++;
        end
        return n;
    endfunction

    task automatic applyStimulus(input int period, input int high, input int phase);
        gen_period = period;
        gen_high   = high;
        gen_phase  = phase;
    endtask

    // Model of the meter evaluated right after each clock edge
    task automatic checkOutput();
        bit was_active;
        bit exp_valid;
        bit exp_pv;
        int n;
        was_active = m_active;
        exp_valid  = 1'b0;
        if (rst) begin
            if (was_active && cyc == m_s + GC + 2) begin
                n         = count_rises(m_s - 1, m_s + GC - 2);
                exp_valid = 1'b1;
                m_freq    = 64'(n);
                m_ovf     = 1'b0;
                if (cont) m_s = m_s + GC + 1;
                else m_active = 1'b0;
            end else if (!was_active && start) begin
                m_active = 1'b1;
                m_s      = cyc - 1;
            end
        end
        check("freq_valid", 64'(freq_valid), 64'(exp_valid));
        check("busy", 64'(busy), 64'(m_active));
        check("freq_out", 64'(freq_out), m_freq);
        check("ovf", 64'(ovf), 64'(m_ovf));
        if (freq_valid) valid_cnt++;
`ifdef PERIOD_MEAS_EN
        exp_pv = (pq.size() > 0) && (pq[0].t == cyc);
        check("period_valid", 64'(period_valid), 64'(exp_pv));
        if (exp_pv) begin
            check("period_out", 64'(period_out), 64'(pq[0].v));
            void'(pq.pop_front());
        end
        if (period_valid) pulse_cnt++;
`else
        exp_pv = 1'b0;
        check("period_out_idle", 64'(period_out), 64'd0);
        check("period_valid_idle", 64'(period_valid), 64'(exp_pv));
`endif
    endtask

    task automatic tick();
        bit   v;
        pev_t e;
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
        v = 1'b0;
        if (gen_period > 0) v = (((cyc + gen_phase) % gen_period) < gen_high);
        sig_in = v;
        if (cyc < MAXC) hist[cyc] = v;
        if (rst && v && cyc < MAXC && !hist[cyc-1]) begin
            if (prev_rise >= 0) begin
                e.t = cyc + 3;
                e.v = cyc - prev_rise;
                pq.push_back(e);
            end
            prev_rise = cyc;
        end
    endtask

    task automatic waitValid(input int budget, output int vc);
        vc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (freq_valid) begin
                vc = cyc;
                break;
            end
        end
        if (vc < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_freq_valid: got no pulse within %0d cycles, required one", budget);
        end
    endtask

    task automatic pulseStart(output int s);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    // Asynchronous reset with immediate checks while the clock is mid-cycle
    task automatic doReset();
        applyStimulus(0, 0, 0);
        repeat (5) tick();
        rst = 1'b0;
        m_active = 1'b0;
        m_freq = '0;
        m_ovf = 1'b0;
        pq.delete();
        prev_rise = -1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_freq_out", 64'(freq_out), 64'd0);
        check("rst_freq_valid", 64'(freq_valid), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_period_out", 64'(period_out), 64'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        int s;
        int v1;
        int v2;
        int v3;
        int n;
        int vc;
        int base;
        int per;
        int hi;

        vecs[0] = '{10, 5, 99, 101};
        vecs[1] = '{20, 10, 49, 51};
        vecs[2] = '{2, 1, 499, 501};
        vecs[3] = '{0, 0, 0, 0};
        vecs[4] = '{3, 1, 332, 335};
        vecs[5] = '{7, 3, 141, 144};

        repeat (3) tick();
        check("init_busy", 64'(busy), 64'd0);
        check("init_freq_out", 64'(freq_out), 64'd0);
        rst = 1'b1;
        repeat (5) tick();

        // Table of single gates with spec-level result ranges
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].period, vecs[i].high, 0);
            repeat (20) tick();
            pulseStart(s);
            waitValid(GC + 50, vc);
            check("vec_latency", 64'(vc - s), 64'(GC + 2));
            check("vec_in_range", 64'((freq_out >= 32'(vecs[i].lo)) && (freq_out <= 32'(vecs[i].hi))), 64'd1);
            check("vec_ovf", 64'(ovf), 64'd0);
            tick();
            check("vec_busy_after", 64'(busy), 64'd0);
        end

        // Continuous mode, three gates, cont dropped during the third
        applyStimulus(10, 5, 0);
        cont = 1'b1;
        pulseStart(s);
        waitValid(GC + 50, v1);
        check("cont_g1_range", 64'((freq_out >= 99) && (freq_out <= 101)), 64'd1);
        waitValid(GC + 50, v2);
        check("cont_g2_range", 64'((freq_out >= 99) && (freq_out <= 101)), 64'd1);
        cont = 1'b0;
        repeat (10) tick();
        check("cont_busy_mid", 64'(busy), 64'd1);
        waitValid(GC + 50, v3);
        check("cont_g3_range", 64'((freq_out >= 99) && (freq_out <= 101)), 64'd1);
        check("cont_spacing_12", 64'(v2 - v1), 64'(GC + 1));
        check("cont_spacing_23", 64'(v3 - v2), 64'(GC + 1));
        repeat (3) tick();
        check("cont_idle_after", 64'(busy), 64'd0);

        // Reset in the middle of a gate discards everything
        applyStimulus(10, 5, 0);
        pulseStart(s);
        repeat (494) tick();
        doReset();
        base = valid_cnt;
        repeat (GC + 200) tick();
        check("no_valid_after_reset", 64'(valid_cnt - base), 64'd0);
        check("freq_out_after_reset", 64'(freq_out), 64'd0);

        // Silent input plus an ignored second start
        applyStimulus(0, 0, 0);
        base = valid_cnt;
        pulseStart(s);
        repeat (300) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        waitValid(GC + 50, vc);
        check("silent_freq_out", 64'(freq_out), 64'd0);
        repeat (GC + 100) tick();
        check("single_valid_only", 64'(valid_cnt - base), 64'd1);

        // Narrow counter saturates, then a small count clears ovf
        applyStimulus(20, 10, 0);
        repeat (10) tick();
        for (int g = 0; g < 2; g++) begin
            if (g == 1) begin
                applyStimulus(100, 50, 0);
                repeat (10) tick();
            end
            start4 = 1'b1;
            s = cyc;
            tick();
            start4 = 1'b0;
            vc = -1;
            for (int i = 0; i < GC + 50; i++) begin
                tick();
                if (freq_valid4) begin
                    vc = cyc;
                    break;
                end
            end
            n = count_rises(s - 1, s + GC - 2);
            check("narrow_latency", 64'(vc - s), 64'(GC + 2));
            check("narrow_freq_out", 64'(freq_out4), 64'((n > 15) ? 15 : n));
            check("narrow_ovf", 64'(ovf4), 64'(n > 15));
        end
        check("narrow_ovf_clear", 64'(ovf4), 64'd0);
        check("narrow_small_count", 64'(freq_out4), 64'd10);

        // Randomized gates, some in continuous mode
        for (int r = 0; r < 4; r++) begin
            per = int'($urandom_range(40, 2));
            hi = int'($urandom_range(per - 1, 1));
            applyStimulus(per, hi, int'($urandom_range(per - 1, 0)));
            repeat (int'($urandom_range(50, 1))) tick();
            cont = (r % 2 == 1);
            pulseStart(s);
            waitValid(GC + 50, vc);
            cont = 1'b0;
            check("rand_freq_out", 64'(freq_out), 64'(count_rises(s - 1, s + GC - 2)));
            if (r % 2 == 1) begin
                waitValid(GC + 50, vc);
            end
            repeat (5) tick();
        end

        // Period measurement at 37 clk
        doReset();
        pulse_cnt = 0;
        applyStimulus(37, 12, 0);
        repeat (37 * 12) tick();
`ifdef PERIOD_MEAS_EN
        check("period_pulses_seen", 64'(pulse_cnt >= 9), 64'd1);
        check("period_last_value", 64'(period_out), 64'd37);
`else
        check("period_pulses_none", 64'(pulse_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
